// File: rtl/execute_stage_if.sv
// Decode-to-EX/MEM bundle: decode-stage registered outputs and hazard controls
// in, EX/MEM pipeline register contents and condition codes out.
// Ports: slave = execute stage (consumes decode, drives EX/MEM); master = driver.
interface execute_stage_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
);
  // decode side / hazard control
  logic              in_valid;
  logic              stall;
  logic              flush;
  logic [1:0]        ALUOp;
  logic              WB_ALUtoReg;
  logic              RegWrite;
  logic              MemRead;
  logic              MemWrite;
  logic [WIDTH-1:0]  read_data1;
  logic [WIDTH-1:0]  read_data2;
  logic [WIDTH-1:0]  sign_extend_in;
  logic [ADDR_W-1:0] reg_write_address;
  // EX/MEM side
  logic [WIDTH-1:0]  alu_result_r;
  logic [WIDTH-1:0]  store_data_r;
  logic              WB_ALUtoReg_r;
  logic              RegWrite_r;
  logic              MemRead_r;
  logic              MemWrite_r;
  logic [ADDR_W-1:0] reg_write_address_r;
  logic              valid_r;
  logic [2:0]        ccr_r;

  modport slave (
    input  in_valid, stall, flush, ALUOp, WB_ALUtoReg, RegWrite, MemRead, MemWrite,
           read_data1, read_data2, sign_extend_in, reg_write_address,
    output alu_result_r, store_data_r, WB_ALUtoReg_r, RegWrite_r, MemRead_r,
           MemWrite_r, reg_write_address_r, valid_r, ccr_r
  );

  modport master (
    output in_valid, stall, flush, ALUOp, WB_ALUtoReg, RegWrite, MemRead, MemWrite,
           read_data1, read_data2, sign_extend_in, reg_write_address,
    input  alu_result_r, store_data_r, WB_ALUtoReg_r, RegWrite_r, MemRead_r,
           MemWrite_r, reg_write_address_r, valid_r, ccr_r
  );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: combinational ALU (ADD/SUB/AND/ADDI) feeding the EX/MEM register and a {C,N,Z} CCR.
// Latency: 1 cycle input to registered outputs; 1 instruction/cycle when not stalled.
// Backpressure: stall holds EX/MEM and CCR (flush ignored while stalled); flush inserts a bubble.
// Ports: clk, rst (sync, active-high); bus = execute_stage_if.slave carrying decode inputs and EX/MEM outputs.
module execute_stage #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input logic            clk,
  input logic            rst,
  execute_stage_if.slave bus
);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_ADDI = 2'b11;

  logic [WIDTH:0]   sum_ab;
  logic [WIDTH:0]   diff_ab;
  logic [WIDTH:0]   sum_imm;
  logic [WIDTH-1:0] alu_res;
  logic             carry;
  logic [2:0]       ccr_next;
  logic             ccr_upd;

  // Extended-width arithmetic: bit WIDTH of the sum is carry-out; for the
  // subtraction it is the borrow, i.e. set exactly when A < B unsigned.
  assign sum_ab  = {1'b0, bus.read_data1} + {1'b0, bus.read_data2};
  assign diff_ab = {1'b0, bus.read_data1} - {1'b0, bus.read_data2};
  assign sum_imm = {1'b0, bus.read_data1} + {1'b0, bus.sign_extend_in};

  always_comb begin
    alu_res = '0;
    carry   = 1'b0;
    case (bus.ALUOp)
      OP_ADD: begin
        alu_res = sum_ab[WIDTH-1:0];
        carry   = sum_ab[WIDTH];
      end
      OP_SUB: begin
        alu_res = diff_ab[WIDTH-1:0];
        carry   = diff_ab[WIDTH];
      end
      OP_AND: begin
        alu_res = bus.read_data1 & bus.read_data2;
        carry   = 1'b0;
      end
      OP_ADDI: begin
        alu_res = sum_imm[WIDTH-1:0];
        carry   = 1'b0;
      end
      default: begin
        alu_res = '0;
        carry   = 1'b0;
      end
    endcase
  end

  assign ccr_next = {carry, alu_res[WIDTH-1], (alu_res == '0)};
  // ADDI is address generation only, so it leaves the flags alone.
  assign ccr_upd  = bus.in_valid && (bus.ALUOp != OP_ADDI);

  // Priority: rst > stall > flush > normal capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.alu_result_r        <= '0;
      bus.store_data_r        <= '0;
      bus.WB_ALUtoReg_r       <= 1'b0;
      bus.RegWrite_r          <= 1'b0;
      bus.MemRead_r           <= 1'b0;
      bus.MemWrite_r          <= 1'b0;
      bus.reg_write_address_r <= '0;
      bus.valid_r             <= 1'b0;
      bus.ccr_r               <= 3'b000;
    end else if (bus.stall) begin
      // hold everything; a coincident flush is dropped and re-issued later
    end else if (bus.flush) begin
      bus.alu_result_r        <= '0;
      bus.store_data_r        <= '0;
      bus.WB_ALUtoReg_r       <= 1'b0;
      bus.RegWrite_r          <= 1'b0;
      bus.MemRead_r           <= 1'b0;
      bus.MemWrite_r          <= 1'b0;
      bus.reg_write_address_r <= '0;
      bus.valid_r             <= 1'b0;
    end else begin
      bus.alu_result_r        <= alu_res;
      bus.store_data_r        <= bus.read_data2;
      bus.reg_write_address_r <= bus.reg_write_address;
      // control is qualified so an empty slot can never write anywhere
      bus.WB_ALUtoReg_r       <= bus.WB_ALUtoReg & bus.in_valid;
      bus.RegWrite_r          <= bus.RegWrite    & bus.in_valid;
      bus.MemRead_r           <= bus.MemRead     & bus.in_valid;
      bus.MemWrite_r          <= bus.MemWrite    & bus.in_valid;
      bus.valid_r             <= bus.in_valid;
      if (ccr_upd) begin
        bus.ccr_r <= ccr_next;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: hand-computed vectors covering reset, ALU ops,
// flag behaviour, stall hold, flush bubble, stall+flush, invalid slot and mid-run reset.
// Outputs are sampled 1 time unit after each rising edge; inputs change at that point too.
module tb_execute_stage;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 3;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  execute_stage_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  execute_stage #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] imm, input logic wb,
                       input logic rw, input logic mr, input logic mw, input logic [2:0] dest);
    bus.in_valid          = v;
    bus.ALUOp             = op;
    bus.read_data1        = a;
    bus.read_data2        = b;
    bus.sign_extend_in    = imm;
    bus.WB_ALUtoReg       = wb;
    bus.RegWrite          = rw;
    bus.MemRead           = mr;
    bus.MemWrite          = mw;
    bus.reg_write_address = dest;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst       = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, 2'b00, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    // 1. reset then idle
    step();
    chk("rst_alu",   bus.alu_result_r, 32'h0);
    chk("rst_store", bus.store_data_r, 32'h0);
    chk("rst_ccr",   bus.ccr_r, 32'h0);
    chk("rst_valid", bus.valid_r, 32'h0);
    chk("rst_ctrl",  {bus.WB_ALUtoReg_r, bus.RegWrite_r, bus.MemRead_r, bus.MemWrite_r}, 32'h0);
    chk("rst_dest",  bus.reg_write_address_r, 32'h0);
    rst = 1'b0;
    step();
    chk("idle_valid", bus.valid_r, 32'h0);

    // 2. ADD with carry-out and zero result
    drive(1'b1, 2'b00, 16'hFFFF, 16'h0001, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3);
    step();
    chk("add_res",   bus.alu_result_r, 32'h0000);
    chk("add_ccr",   bus.ccr_r, 32'h5);
    chk("add_rw",    bus.RegWrite_r, 32'h1);
    chk("add_wb",    bus.WB_ALUtoReg_r, 32'h1);
    chk("add_dest",  bus.reg_write_address_r, 32'h3);
    chk("add_valid", bus.valid_r, 32'h1);
    chk("add_store", bus.store_data_r, 32'h0001);

    // 3. SUB with borrow, then ADDI leaves flags
    drive(1'b1, 2'b01, 16'h0003, 16'h0005, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2);
    step();
    chk("sub_res", bus.alu_result_r, 32'hFFFE);
    chk("sub_ccr", bus.ccr_r, 32'h6);
    drive(1'b1, 2'b11, 16'h0010, 16'h1234, 16'hFFFC, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5);
    step();
    chk("addi_res",   bus.alu_result_r, 32'h000C);
    chk("addi_mr",    bus.MemRead_r, 32'h1);
    chk("addi_mw",    bus.MemWrite_r, 32'h1);
    chk("addi_rw",    bus.RegWrite_r, 32'h0);
    chk("addi_store", bus.store_data_r, 32'h1234);
    chk("addi_ccr",   bus.ccr_r, 32'h6);

    // 4. AND then 3-cycle stall with changing inputs
    drive(1'b1, 2'b10, 16'h00F0, 16'h0FF0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1);
    step();
    chk("and_res", bus.alu_result_r, 32'h00F0);
    chk("and_ccr", bus.ccr_r, 32'h0);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b00, 16'hFFFF, 16'h0001 + 16'(i), 16'h0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd7);
      step();
      chk("stall_res",  bus.alu_result_r, 32'h00F0);
      chk("stall_ccr",  bus.ccr_r, 32'h0);
      chk("stall_dest", bus.reg_write_address_r, 32'h1);
    end
    bus.stall = 1'b0;
    drive(1'b1, 2'b01, 16'h0000, 16'h0001, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4);
    step();
    chk("rel_res",  bus.alu_result_r, 32'hFFFF);
    chk("rel_ccr",  bus.ccr_r, 32'h6);
    chk("rel_dest", bus.reg_write_address_r, 32'h4);

    // 5. flush with a valid ADD that would otherwise set flags 101
    bus.flush = 1'b1;
    drive(1'b1, 2'b00, 16'hFFFF, 16'h0001, 16'h0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd6);
    step();
    chk("flush_valid", bus.valid_r, 32'h0);
    chk("flush_ctrl",  {bus.WB_ALUtoReg_r, bus.RegWrite_r, bus.MemRead_r, bus.MemWrite_r}, 32'h0);
    chk("flush_res",   bus.alu_result_r, 32'h0);
    chk("flush_store", bus.store_data_r, 32'h0);
    chk("flush_dest",  bus.reg_write_address_r, 32'h0);
    chk("flush_ccr",   bus.ccr_r, 32'h6);
    bus.flush = 1'b0;
    drive(1'b1, 2'b00, 16'h0002, 16'h0003, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2);
    step();
    chk("pre_sf_res", bus.alu_result_r, 32'h0005);
    chk("pre_sf_ccr", bus.ccr_r, 32'h0);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    drive(1'b1, 2'b01, 16'h0000, 16'h0001, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    step();
    chk("sf_res",   bus.alu_result_r, 32'h0005);
    chk("sf_valid", bus.valid_r, 32'h1);
    chk("sf_rw",    bus.RegWrite_r, 32'h1);
    chk("sf_ccr",   bus.ccr_r, 32'h0);
    bus.stall = 1'b0;
    bus.flush = 1'b0;

    // 6. invalid slot: control suppressed, data still captured, flags held
    drive(1'b0, 2'b00, 16'h0007, 16'h8001, 16'h0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd5);
    step();
    chk("inv_rw",    bus.RegWrite_r, 32'h0);
    chk("inv_mw",    bus.MemWrite_r, 32'h0);
    chk("inv_wb",    bus.WB_ALUtoReg_r, 32'h0);
    chk("inv_valid", bus.valid_r, 32'h0);
    chk("inv_res",   bus.alu_result_r, 32'h8008);
    chk("inv_dest",  bus.reg_write_address_r, 32'h5);
    chk("inv_ccr",   bus.ccr_r, 32'h0);

    // 7. reset mid-operation discards the in-flight instruction
    drive(1'b1, 2'b01, 16'h0001, 16'h0002, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd7);
    step();
    chk("pre_rst_ccr", bus.ccr_r, 32'h6);
    rst = 1'b1;
    step();
    chk("mrst_valid", bus.valid_r, 32'h0);
    chk("mrst_res",   bus.alu_result_r, 32'h0);
    chk("mrst_ccr",   bus.ccr_r, 32'h0);
    chk("mrst_rw",    bus.RegWrite_r, 32'h0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
